// File: rtl/hf14a_pkg.sv
// Shared types and defaults for the ISO14443-A tag-to-reader receive path.
package hf14a_pkg;

  localparam int SAMPLES_PER_BIT_DEF = 8;
  localparam int HALF_HIT_MIN_DEF    = 2;

  typedef enum logic [1:0] {SYM_D, SYM_E, SYM_F, SYM_X} sym_e;
  typedef enum logic [1:0] {IDLE, SOF, RX} state_e;

  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/hf14a_symbol_classifier.sv
// Counts modulated detector samples per half-bit and classifies each Manchester
// symbol (D/E/F/X) on the last sample of the bit period.
module hf14a_symbol_classifier
  import hf14a_pkg::*;
#(
  parameter int SAMPLES_PER_BIT = SAMPLES_PER_BIT_DEF,
  parameter int HALF_HIT_MIN    = HALF_HIT_MIN_DEF
) (
  input  logic osc_clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  input  logic sample,
  output logic sym_valid,
  output sym_e sym
);

  localparam int            PW       = $clog2(SAMPLES_PER_BIT);
  localparam logic [PW-1:0] PH_HALF  = PW'(SAMPLES_PER_BIT / 2);
  localparam logic [PW-1:0] PH_LAST  = PW'(SAMPLES_PER_BIT - 1);
  localparam logic [2:0]    HIT_MIN  = 3'(HALF_HIT_MIN);

  logic [PW-1:0] ph_q, ph_d;
  logic [2:0]    h1_q, h1_d, h2_q, h2_d;
  logic [2:0]    h1_n, h2_n;
  logic          m1, m2;

  always_comb begin
    ph_d      = ph_q;
    h1_d      = h1_q;
    h2_d      = h2_q;
    h1_n      = h1_q;
    h2_n      = h2_q;
    sym_valid = 1'b0;
    sym       = SYM_F;

    // half-bit hit counts include the current sample, saturating at 7
    if (count_en && sample) begin
      if (ph_q < PH_HALF) h1_n = (h1_q == 3'd7) ? h1_q : h1_q + 3'd1;
      else                h2_n = (h2_q == 3'd7) ? h2_q : h2_q + 3'd1;
    end
    m1 = (h1_n >= HIT_MIN);
    m2 = (h2_n >= HIT_MIN);

    if (count_en) begin
      if (ph_q == PH_LAST) begin
        sym_valid = 1'b1;
        ph_d      = '0;
        h1_d      = '0;
        h2_d      = '0;
        case ({m1, m2})
          2'b10:   sym = SYM_D;
          2'b01:   sym = SYM_E;
          2'b11:   sym = SYM_X;
          default: sym = SYM_F;
        endcase
      end else begin
        ph_d = ph_q + PW'(1);
        h1_d = h1_n;
        h2_d = h2_n;
      end
    end

    if (clear) begin
      ph_d      = '0;
      h1_d      = '0;
      h2_d      = '0;
      sym_valid = 1'b0;
    end
  end

  always_ff @(negedge osc_clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q <= '0;
      h1_q <= '0;
      h2_q <= '0;
    end else begin
      ph_q <= ph_d;
      h1_q <= h1_d;
      h2_q <= h2_d;
    end
  end

endmodule

// File: rtl/hf14a_tag_rx_decoder.sv
// ISO14443-A tag-to-reader decoder: frames SOF/EOF, packs LSB-first 9-bit words
// and presents them on a valid/ready port with parity, collision and overflow flags.
//
// state | meaning
// IDLE  | waiting for the first modulated sample of a possible SOF
// SOF   | collecting the first symbol; only D opens a frame
// RX    | collecting data/parity bits until an F symbol (EOF)
module hf14a_tag_rx_decoder
  import hf14a_pkg::*;
#(
  parameter int SAMPLES_PER_BIT = SAMPLES_PER_BIT_DEF,
  parameter int HALF_HIT_MIN    = HALF_HIT_MIN_DEF
) (
  input  logic       osc_clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       sample_valid,
  input  logic       sample,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_parity,
  output logic [3:0] out_nbits,
  output logic       out_parity_err,
  output logic       out_collision,
  output logic       frame_active,
  output logic       frame_end,
  output logic       overflow
);

  state_e     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic       wcoll_q, wcoll_d;
  logic       frame_active_q, frame_active_d, frame_end_q, frame_end_d;
  logic       overflow_q, overflow_d, out_valid_q, out_valid_d;
  logic [7:0] out_data_q, out_data_d;
  logic       out_parity_q, out_parity_d, out_perr_q, out_perr_d, out_coll_q, out_coll_d;
  logic [3:0] out_nbits_q, out_nbits_d;

  logic       emit, em_par, em_perr, em_coll, ovf_clr, bit_val, count_en, sym_valid;
  logic [7:0] em_data;
  logic [3:0] em_nbits;
  sym_e       sym;

  // once a symbol is under way every strobe counts; from IDLE only a hit starts one
  assign count_en = enable && sample_valid && ((state_q != IDLE) || sample);

  hf14a_symbol_classifier #(
    .SAMPLES_PER_BIT (SAMPLES_PER_BIT),
    .HALF_HIT_MIN    (HALF_HIT_MIN)
  ) u_classifier (
    .osc_clk   (osc_clk),
    .rst_n     (rst_n),
    .clear     (!enable),
    .count_en  (count_en),
    .sample    (sample),
    .sym_valid (sym_valid),
    .sym       (sym)
  );

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    shreg_d        = shreg_q;
    wcoll_d        = wcoll_q;
    frame_active_d = frame_active_q;
    frame_end_d    = 1'b0;
    emit           = 1'b0;
    em_data        = shreg_q;
    em_par         = 1'b0;
    em_nbits       = bit_cnt_q;
    em_perr        = 1'b0;
    em_coll        = wcoll_q;
    ovf_clr        = 1'b0;
    bit_val        = (sym == SYM_D) || (sym == SYM_X);

    if (!enable) begin
      state_d        = IDLE;
      bit_cnt_d      = '0;
      shreg_d        = '0;
      wcoll_d        = 1'b0;
      frame_active_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (sample_valid && sample) state_d = SOF;
        SOF: if (sym_valid) begin
          if (sym == SYM_D) begin
            state_d        = RX;
            frame_active_d = 1'b1;
            bit_cnt_d      = '0;
            shreg_d        = '0;
            wcoll_d        = 1'b0;
            ovf_clr        = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        RX: if (sym_valid) begin
          if (sym == SYM_F) begin
            emit           = (bit_cnt_q != 4'd0);
            frame_end_d    = 1'b1;
            frame_active_d = 1'b0;
            state_d        = IDLE;
            bit_cnt_d      = '0;
            shreg_d        = '0;
            wcoll_d        = 1'b0;
          end else if (bit_cnt_q == 4'd8) begin
            emit      = 1'b1;
            em_par    = bit_val;
            em_nbits  = 4'd9;
            em_perr   = !odd_parity_ok(shreg_q, bit_val);
            em_coll   = wcoll_q || (sym == SYM_X);
            bit_cnt_d = '0;
            shreg_d   = '0;
            wcoll_d   = 1'b0;
          end else begin
            shreg_d[bit_cnt_q[2:0]] = bit_val;
            bit_cnt_d               = bit_cnt_q + 4'd1;
            wcoll_d                 = wcoll_q || (sym == SYM_X);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_parity_d = out_parity_q;
    out_nbits_d  = out_nbits_q;
    out_perr_d   = out_perr_q;
    out_coll_d   = out_coll_q;
    overflow_d   = ovf_clr ? 1'b0 : overflow_q;

    // a word that arrives while the held one is not being taken is dropped
    if (emit) begin
      if (out_valid_q && !out_ready) begin
        overflow_d = 1'b1;
      end else begin
        out_valid_d  = 1'b1;
        out_data_d   = em_data;
        out_parity_d = em_par;
        out_nbits_d  = em_nbits;
        out_perr_d   = em_perr;
        out_coll_d   = em_coll;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(negedge osc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      shreg_q        <= '0;
      wcoll_q        <= 1'b0;
      frame_active_q <= 1'b0;
      frame_end_q    <= 1'b0;
      overflow_q     <= 1'b0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_parity_q   <= 1'b0;
      out_nbits_q    <= '0;
      out_perr_q     <= 1'b0;
      out_coll_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      shreg_q        <= shreg_d;
      wcoll_q        <= wcoll_d;
      frame_active_q <= frame_active_d;
      frame_end_q    <= frame_end_d;
      overflow_q     <= overflow_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_parity_q   <= out_parity_d;
      out_nbits_q    <= out_nbits_d;
      out_perr_q     <= out_perr_d;
      out_coll_q     <= out_coll_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign out_parity     = out_parity_q;
  assign out_nbits      = out_nbits_q;
  assign out_parity_err = out_perr_q;
  assign out_collision  = out_coll_q;
  assign frame_active   = frame_active_q;
  assign frame_end      = frame_end_q;
  assign overflow       = overflow_q;

endmodule

// File: doc/hf14a_tag_rx_decoder.md
Name: hf14a_tag_rx_decoder

Overview:
- Downstream consumer of the 848 kHz modulation detector's per-slot `curbit` decision in READER_LISTEN mode.
- Decodes ISO14443-A tag-to-reader Manchester symbols (sequences D/E/F) from one detector sample per 16 carrier clocks.
- Frames SOF/EOF, packs LSB-first bits into 9-bit words (8 data + odd parity) and hands each word over a valid/ready interface to the ARM-side serialiser.
- Flags parity errors, collisions and overflow.

Parameters:
- SAMPLES_PER_BIT, 8, detector samples per ISO14443-A bit (128 carrier clocks / 16); must be even.
- HALF_HIT_MIN, 2, minimum modulated samples in a half-bit for that half to count as modulated.

Ports:
- osc_clk  in  1  13.56 MHz carrier clock; all flops on falling edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  decoder active (major mode READER_LISTEN); low forces IDLE.
- sample_valid  in  1  one-cycle strobe, once per 16 osc_clk, when `sample` is fresh.
- sample  in  1  modulation detected in the last 16-clock slot.
- out_ready  in  1  consumer accepts the word.
- out_valid  out  1  word available.
- out_data  out  8  received data bits, LSB first, LSB-aligned.
- out_parity  out  1  received parity bit; 0 when out_nbits<9.
- out_nbits  out  4  valid bits in word: 9 = full byte+parity, 1..8 = partial final word.
- out_parity_err  out  1  full word whose parity is not odd.
- out_collision  out  1  at least one symbol in the word had both halves modulated.
- frame_active  out  1  high from accepted SOF until EOF/abort.
- frame_end  out  1  one-cycle pulse on EOF.
- overflow  out  1  sticky: a word was dropped; cleared only by reset or entering a new frame.

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0.
- The decoder only advances on cycles with sample_valid=1; other cycles hold state.
- Phase counter ph: 0..SAMPLES_PER_BIT-1.
  - h1 counts samples=1 in phases 0..3; h2 counts samples=1 in phases 4..7 (3-bit each).
  - At ph=7 (inclusive of that sample), the symbol is classified, with m1=(h1>=HALF_HIT_MIN) and m2=(h2>=HALF_HIT_MIN):
    - m1&!m2 = D (logic 1)
    - !m1&m2 = E (logic 0)
    - !m1&!m2 = F (no modulation)
    - m1&m2 = X (collision, decoded as 1, sets word collision flag).
- States:
  - IDLE: on sample_valid&&sample, go to SOF with ph=1, h1=1, h2=0.
  - SOF: on classification, D -> RX (frame_active=1, bit_cnt=0, overflow cleared); X or anything else -> IDLE without output.
  - RX: on classification:
    - D/E/X: shift bit into bit position bit_cnt.
      - bit_cnt 0..7 are data; bit_cnt 8 is parity.
      - After the parity bit: emit word with out_nbits=9, out_parity_err = ~(^{data,parity}), then bit_cnt=0.
    - F: EOF. If bit_cnt>0, emit partial word (out_nbits=bit_cnt, out_parity=0, out_parity_err=0). Pulse frame_end, clear frame_active, go to IDLE.
- Emit timing: the word is registered one osc_clk after the classifying sample_valid cycle; out_valid rises the same cycle. frame_end is coincident with a partial word's out_valid rise.
- Handshake:
  - out_valid is held with stable data until an out_valid&&out_ready cycle.
  - Emit while out_valid && !out_ready: new word dropped, overflow=1, held word unchanged.
  - Emit in the same cycle as out_valid&&out_ready: the new word loads and out_valid stays 1.
- enable low in any state: next cycle IDLE, partial bits discarded, frame_active=0, no frame_end, no emit. A pending out_valid word is retained.
- Counters saturate or are reset explicitly; no wrap beyond declared ranges.

Decomposition:
- Shared package hf14a_pkg: symbol enum (SYM_D, SYM_E, SYM_F, SYM_X), state enum (IDLE, SOF, RX), constants SAMPLES_PER_BIT_DEF=8 and HALF_HIT_MIN_DEF=2.
- One natural sub-module: hf14a_symbol_classifier (ph/h1/h2 counters and symbol output strobe). The parent holds the FSM, bit packer and output register.

Test Plan:
- Samples 11110000 (SOF), then bits 0,1,1,0,0,1,0 as E/D symbols, then 00000000 -> one word out_data=0x26, out_nbits=7, out_parity=0, frame_end pulse, frame_active low afterwards.
- SOF, byte 0x93 LSB first + parity 1, F -> out_data=0x93, out_nbits=9, out_parity=1, out_parity_err=0. Repeat with parity 0 -> out_parity_err=1.
- Lone sample=1 followed by seven 0 (glitch, classifies F) -> no word, frame_active never asserts, state returns to IDLE.
- Symbol 11110111 inside a byte -> bit decoded 1, out_collision=1 on that word only.
- Two full words with out_ready=0 throughout -> first word held, second dropped, overflow=1. Then out_ready=1 for one cycle -> out_valid falls, overflow stays 1.
- enable dropped after 4 data bits, then rst_n pulsed low mid-frame -> no word, no frame_end. After reset, all outputs 0 asynchronously.
